// File: rtl/rst_pkg.sv
// Shared definitions for the software reset controller.
// State encoding and default hold/timeout settings.
package rst_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        ASSERT       = 2'd1,
        WAIT_RELEASE = 2'd2,
        REPORT       = 2'd3
    } state_t;

    localparam int HOLD_DEFAULT    = 16;
    localparam int TIMEOUT_DEFAULT = 64;
    localparam int CNT_W_DEFAULT   = 8;

endpackage

// File: rtl/sw_reset_ctrl.sv
// Software reset sequencer: stretches a request into software_rst,
// then confirms the synchronized internal_rst asserted and released.
module sw_reset_ctrl
    import rst_pkg::*;
#(
    parameter int HOLD_CYCLES    = HOLD_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       hardware_rst_n,
    input  logic       req,
    input  logic       internal_rst,
    output logic       software_rst,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] rst_count
);

    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seen_q, seen_d;
    logic             sw_d, busy_d, done_d, err_d;
    logic [7:0]       count_d;

    always_ff @(posedge clk or negedge hardware_rst_n) begin
        if (!hardware_rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            seen_q       <= 1'b0;
            software_rst <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            rst_count    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            seen_q       <= seen_d;
            software_rst <= sw_d;
            busy         <= busy_d;
            done         <= done_d;
            error        <= err_d;
            rst_count    <= count_d;
        end
    end

    // Outputs are computed for the next state so they leave the flops directly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        sw_d    = software_rst;
        busy_d  = busy;
        done_d  = 1'b0;
        err_d   = 1'b0;
        count_d = rst_count;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ASSERT;
                    cnt_d   = HOLD_LD;
                    seen_d  = 1'b0;
                    sw_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ASSERT: begin
                seen_d = seen_q | internal_rst;
                if (cnt_q == '0) begin
                    state_d = WAIT_RELEASE;
                    cnt_d   = TIMEOUT_LD;
                    sw_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WAIT_RELEASE: begin
                seen_d = seen_q | internal_rst;
                if (!internal_rst && seen_q) begin
                    state_d = REPORT;
                    done_d  = 1'b1;
                    if (rst_count != 8'hFF) begin
                        count_d = rst_count + 8'd1;
                    end
                end else if (cnt_q == '0) begin
                    state_d = REPORT;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            REPORT: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                sw_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sw_reset_ctrl.sv
// Bench for sw_reset_ctrl with a 3-cycle synchronizer loopback
// and a timestamp-based reference model.
module tb_sw_reset_ctrl;

    localparam int HOLD    = 16;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       hardware_rst_n = 1'b1;
    logic       req = 1'b0;
    logic       internal_rst;
    logic       software_rst;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] rst_count;

    int         mode = 0;
    logic       d1, d2, d3;

    sw_reset_ctrl #(
        .HOLD_CYCLES(HOLD),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .hardware_rst_n(hardware_rst_n),
        .req(req),
        .internal_rst(internal_rst),
        .software_rst(software_rst),
        .busy(busy),
        .done(done),
        .error(error),
        .rst_count(rst_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge hardware_rst_n) begin
        if (!hardware_rst_n) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
            d3 <= 1'b0;
        end else begin
            d1 <= software_rst;
            d2 <= d1;
            d3 <= d2;
        end
    end

    assign internal_rst = (mode == 0) ? d3 : (mode == 2);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a sequence accepted in cycle t0 holds software_rst
    // over t0+1..t0+HOLD, then watches the window t0+HOLD+1..t0+HOLD+TIMEOUT.
    logic m_act = 1'b0;
    logic m_seen = 1'b0;
    int   t0 = 0;
    int   rep_at = -1;
    logic e_sw = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
    int   e_cnt = 0;

    always @(posedge clk or negedge hardware_rst_n) begin
        if (!hardware_rst_n) begin
            m_act  = 1'b0;
            m_seen = 1'b0;
            rep_at = -1;
            e_sw   = 1'b0;
            e_busy = 1'b0;
            e_done = 1'b0;
            e_err  = 1'b0;
            e_cnt  = 0;
        end else begin
            e_done = 1'b0;
            e_err  = 1'b0;
            if (!m_act) begin
                if (req) begin
                    m_act  = 1'b1;
                    t0     = cyc;
                    m_seen = 1'b0;
                    rep_at = -1;
                end
            end else if (rep_at == cyc) begin
                m_act = 1'b0;
            end else begin
                if (rep_at < 0 && cyc > t0 + HOLD && cyc <= t0 + HOLD + TIMEOUT) begin
                    if (!internal_rst && m_seen) begin
                        rep_at = cyc + 1;
                        e_done = 1'b1;
                        if (e_cnt < 255) e_cnt = e_cnt + 1;
                    end else if (cyc == t0 + HOLD + TIMEOUT) begin
                        rep_at = cyc + 1;
                        e_err  = 1'b1;
                    end
                end
                if (internal_rst) m_seen = 1'b1;
            end
            e_busy = m_act;
            e_sw   = m_act && (cyc + 1 >= t0 + 1) && (cyc + 1 <= t0 + HOLD);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int done_total = 0, err_total = 0, sw_total = 0;
    int done_at = -1, err_at = -1, fall_at = -1;
    logic prev_busy = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("software_rst", int'(software_rst), int'(e_sw));
        chk("busy", int'(busy), int'(e_busy));
        chk("done", int'(done), int'(e_done));
        chk("error", int'(error), int'(e_err));
        chk("rst_count", int'(rst_count), e_cnt);
        if (done === 1'b1) begin
            done_total = done_total + 1;
            done_at = cyc;
        end
        if (error === 1'b1) begin
            err_total = err_total + 1;
            err_at = cyc;
        end
        if (software_rst === 1'b1) sw_total = sw_total + 1;
        if (prev_busy && busy === 1'b0) fall_at = cyc;
        prev_busy = busy;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_req(output int t);
        req = 1'b1;
        t = cyc;
        step();
        req = 1'b0;
    endtask

    initial begin
        int t, bd, be, bs;
        hardware_rst_n = 1'b0;
        steps(3);
        chk("reset software_rst", int'(software_rst), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset rst_count", int'(rst_count), 0);
        hardware_rst_n = 1'b1;
        steps(2);

        // Nominal
        bd = done_total; bs = sw_total;
        pulse_req(t);
        steps(30);
        chk("nom done count", done_total - bd, 1);
        chk("nom done cycle", done_at - t, 21);
        chk("nom sw width", sw_total - bs, 16);
        chk("nom busy fall", fall_at - t, 22);
        chk("nom rst_count", int'(rst_count), 1);

        // Second request while busy is dropped
        bd = done_total; bs = sw_total;
        pulse_req(t);
        steps(7);
        req = 1'b1;
        step();
        req = 1'b0;
        steps(30);
        chk("drop done count", done_total - bd, 1);
        chk("drop done cycle", done_at - t, 21);
        chk("drop sw width", sw_total - bs, 16);
        chk("drop rst_count", int'(rst_count), 2);

        // No feedback
        mode = 1;
        bd = done_total; be = err_total; bs = sw_total;
        pulse_req(t);
        steps(90);
        chk("nofb error count", err_total - be, 1);
        chk("nofb error cycle", err_at - t, 81);
        chk("nofb done count", done_total - bd, 0);
        chk("nofb sw width", sw_total - bs, 16);
        chk("nofb rst_count", int'(rst_count), 2);

        // Stuck feedback
        mode = 2;
        steps(2);
        bd = done_total; be = err_total;
        pulse_req(t);
        steps(90);
        chk("stuck error cycle", err_at - t, 81);
        chk("stuck busy fall", fall_at - t, 82);
        chk("stuck done count", done_total - bd, 0);
        mode = 0;
        steps(5);

        // Reset mid-sequence
        bd = done_total; be = err_total;
        pulse_req(t);
        steps(9);
        hardware_rst_n = 1'b0;
        #1;
        chk("midrst software_rst", int'(software_rst), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst rst_count", int'(rst_count), 0);
        steps(3);
        hardware_rst_n = 1'b1;
        steps(30);
        chk("midrst no done", done_total - bd, 0);
        chk("midrst no error", err_total - be, 0);
        pulse_req(t);
        steps(25);
        chk("post rst done cycle", done_at - t, 21);
        chk("post rst rst_count", int'(rst_count), 1);

        // Saturation
        bd = done_total;
        for (int k = 0; k < 300; k++) begin
            pulse_req(t);
            steps(21);
        end
        steps(3);
        chk("sat done count", done_total - bd, 300);
        chk("sat rst_count", int'(rst_count), 255);
        pulse_req(t);
        steps(25);
        chk("sat done cycle", done_at - t, 21);
        chk("sat rst_count hold", int'(rst_count), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
